tune_field_cursor: RTL
======================

// Module: tune_field_cursor
// PURPOSE
//  Parametrised cursor manager for time/alarm tuning. Selects one of NUM_FIELDS editable
//  fields (1..NUM_FIELDS, 0 = none) from left/right key strobes while the system is in a
//  select mode, and freezes the cursor during a tuning mode. Adds wrap/saturate selection,
//  a one-hot field output, a blink phase for the display and an inactivity timeout.
//  Sits between the system status manager and the digit display/value-adjust logic.
// PARAMETERS
//  NUM_FIELDS   3      number of selectable fields; field 1 = least significant (seconds)
//  START_FIELD  1      field loaded on entry to select mode (1..NUM_FIELDS)
//  WRAP         1      1: wrap at ends; 0: saturate at 1 and NUM_FIELDS
//  KEY_W        4      width of key strobe vector
//  KEY_LEFT     4'b0010  exact strobe code for move-left (toward more significant)
//  KEY_RIGHT    4'b0100  exact strobe code for move-right (toward less significant)
//  BLINK_HALF   25     cycles per blink half-period (>=1)
//  TIMEOUT_CYC  0      idle cycles in select mode before timeout pulse; 0 disables
//  FIELD_W      $clog2(NUM_FIELDS+1)  derived, not overridden
// PORTS
//  clk           in   1          clock
//  rst_n         in   1          reset, asynchronous, active-low
//  key_strobe    in   KEY_W      one-cycle filtered key pulses
//  sel_mode      in   1          system in field-select state (clock or alarm)
//  hold_mode     in   1          system in value-tuning state (clock or alarm)
//  field         out  FIELD_W    selected field, 0 = none
//  field_onehot  out  NUM_FIELDS bit (field-1) set when field != 0, else all 0
//  blink         out  1          display-on phase for selected field
//  moved         out  1          one-cycle pulse when field changes by a key
//  timeout       out  1          one-cycle pulse on select-mode inactivity
// BEHAVIOUR
//  - Reset: field=0, field_onehot=0, blink=0, moved=0, timeout=0, all counters 0.
//  - All outputs registered; key strobe at cycle N is reflected at cycle N+1.
//  - Mode priority: sel_mode > hold_mode > idle (both high treated as select).
//  - Idle: field<=0; blink, timers cleared.
//  - Hold: field unchanged; keys ignored; timeout counter cleared; blink keeps running.
//  - Select, field==0: field<=START_FIELD, keys that cycle ignored, blink<=1, timers cleared.
//  - Select, field in 1..NUM_FIELDS:
//      key==KEY_LEFT : field==NUM_FIELDS ? (WRAP ? 1 : hold) : field+1
//      key==KEY_RIGHT: field==1 ? (WRAP ? NUM_FIELDS : hold) : field-1
//      any other code (incl. LEFT|RIGHT together, multi-key) ignored.
//    moved pulses only if field value actually changes (saturated press -> no pulse).
//  - Select, field > NUM_FIELDS (illegal): field<=0, recovers to START_FIELD next cycle.
//  - Blink: counter counts 0..BLINK_HALF-1 while field!=0, toggles blink at wrap;
//    any valid key press (changed or not) restarts counter with blink<=1.
//  - Timeout (TIMEOUT_CYC>0): counter increments each select cycle with no valid key;
//    at TIMEOUT_CYC-1 -> timeout pulses next cycle, counter restarts; field unchanged
//    (status manager decides exit). Valid key or leaving select clears counter.
//  - Reset mid-operation: immediate return to reset values regardless of mode.
// STRUCTURE
//  - Shared package tune_pkg: T_NONE, key codes, field index of second/minute/hour.
//  - One sub-module cycle_timer (param PERIOD; inputs en, restart; output wrap pulse),
//    instantiated for blink and timeout (timeout instance omitted when TIMEOUT_CYC==0).
//  - Cursor next-state and one-hot decode in this module.
// TESTING (NUM_FIELDS=3, WRAP=1, BLINK_HALF=4, TIMEOUT_CYC=20 unless stated)
//  - Reset then sel_mode=1 -> field=1, onehot=3'b001, blink=1 one cycle after sel_mode.
//  - LEFT x3 from field 1 -> 2,3,1 with moved pulse each; RIGHT from 1 -> 3.
//  - WRAP=0: LEFT at 3 -> stays 3, moved=0; RIGHT at 1 -> stays 1; key 4'b0110 ignored.
//  - Select field=2, switch to hold_mode, press LEFT -> field stays 2; drop both -> 0.
//  - Select, no keys: blink toggles every 4 cycles; timeout pulses after 20 idle cycles,
//    again 20 later; a LEFT at idle cycle 15 delays pulse to 20 cycles after the key.
//  - rst_n low mid-select at field 3 -> all outputs 0 asynchronously; release -> field=1.

Source files
------------

// File: rtl/tune_field_cursor_pkg.sv
// Shared tuning definitions: field indices, key strobe codes, operating mode decode.
// Latency: none (constants and pure functions). Backpressure: not applicable.
package tune_pkg;

  localparam int T_NONE = 0;
  localparam int F_SEC  = 1;
  localparam int F_MIN  = 2;
  localparam int F_HOUR = 3;

  localparam logic [3:0] K_LEFT  = 4'b0010;
  localparam logic [3:0] K_RIGHT = 4'b0100;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_HOLD = 2'd1,
    M_SEL  = 2'd2
  } mode_e;

  // Select wins when the status manager raises both mode lines.
  function automatic mode_e decode_mode(input logic sel, input logic hold);
    if (sel)       return M_SEL;
    else if (hold) return M_HOLD;
    else           return M_IDLE;
  endfunction

endpackage

// File: rtl/tune_field_cursor_timer.sv
// Free-running period counter with restart; wrap is high on the last count of each period.
// Latency: wrap is combinational from the count. Backpressure: none, en simply pauses counting.
module cycle_timer #(
  parameter int PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic wrap
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  assign wrap = en && !restart && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tune_field_cursor.sv
// Cursor over the editable time/alarm fields with one-hot view, blink phase and idle timeout.
// Latency: one cycle from key/mode inputs to every output. Backpressure: none, strobes are one-shot.
module tune_field_cursor
  import tune_pkg::*;
#(
  parameter int                 NUM_FIELDS  = 3,
  parameter int                 START_FIELD = F_SEC,
  parameter bit                 WRAP        = 1'b1,
  parameter int                 KEY_W       = 4,
  parameter logic [KEY_W-1:0]   KEY_LEFT    = KEY_W'(K_LEFT),
  parameter logic [KEY_W-1:0]   KEY_RIGHT   = KEY_W'(K_RIGHT),
  parameter int                 BLINK_HALF  = 25,
  parameter int                 TIMEOUT_CYC = 0,
  localparam int                FIELD_W     = $clog2(NUM_FIELDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEY_W-1:0]      key_strobe,
  input  logic                  sel_mode,
  input  logic                  hold_mode,
  output logic [FIELD_W-1:0]    field,
  output logic [NUM_FIELDS-1:0] field_onehot,
  output logic                  blink,
  output logic                  moved,
  output logic                  timeout
);

  localparam logic [FIELD_W-1:0] F_NONE  = FIELD_W'(T_NONE);
  localparam logic [FIELD_W-1:0] F_ONE   = FIELD_W'(1);
  localparam logic [FIELD_W-1:0] F_MAX   = FIELD_W'(NUM_FIELDS);
  localparam logic [FIELD_W-1:0] F_START = FIELD_W'(START_FIELD);

  function automatic logic [NUM_FIELDS-1:0] to_onehot(input logic [FIELD_W-1:0] f);
    logic [NUM_FIELDS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (int'(f) == i + 1) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  mode_e              mode;
  logic               key_l, key_r, key_vld;
  logic               in_range, sel_live;
  logic [FIELD_W-1:0] field_nxt;
  logic               blink_nxt;
  logic               blink_en, blink_restart, blink_wrap;
  logic               idle_wrap;

  assign mode     = decode_mode(sel_mode, hold_mode);
  assign key_l    = (key_strobe == KEY_LEFT);
  assign key_r    = (key_strobe == KEY_RIGHT);
  assign key_vld  = key_l || key_r;
  assign in_range = (field != F_NONE) && (int'(field) <= NUM_FIELDS);
  assign sel_live = (mode == M_SEL) && in_range;

  always_comb begin
    field_nxt = field;
    unique case (mode)
      M_IDLE: field_nxt = F_NONE;
      M_HOLD: field_nxt = field;
      default: begin
        if (field == F_NONE) begin
          field_nxt = F_START;
        end else if (!in_range) begin
          field_nxt = F_NONE;
        end else if (key_l) begin
          field_nxt = (field == F_MAX) ? (WRAP ? F_ONE : field) : field + F_ONE;
        end else if (key_r) begin
          field_nxt = (field == F_ONE) ? (WRAP ? F_MAX : field) : field - F_ONE;
        end
      end
    endcase
  end

  // A key press (even a saturated one) restarts the blink so the cursor is visibly on.
  assign blink_en      = in_range && (mode != M_IDLE);
  assign blink_restart = (mode == M_IDLE) || ((mode == M_SEL) && (!in_range || key_vld));

  always_comb begin
    blink_nxt = blink;
    unique case (mode)
      M_IDLE: blink_nxt = 1'b0;
      M_HOLD: blink_nxt = blink ^ blink_wrap;
      default: begin
        if (field == F_NONE)   blink_nxt = 1'b1;
        else if (!in_range)    blink_nxt = 1'b0;
        else if (key_vld)      blink_nxt = 1'b1;
        else                   blink_nxt = blink ^ blink_wrap;
      end
    endcase
  end

  cycle_timer #(.PERIOD(BLINK_HALF)) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (blink_en),
    .restart (blink_restart),
    .wrap    (blink_wrap)
  );

  if (TIMEOUT_CYC > 0) begin : g_timeout
    cycle_timer #(.PERIOD(TIMEOUT_CYC)) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (sel_live && !key_vld),
      .restart (!sel_live || key_vld),
      .wrap    (idle_wrap)
    );
  end else begin : g_no_timeout
    assign idle_wrap = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field        <= F_NONE;
      field_onehot <= '0;
      blink        <= 1'b0;
      moved        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      field        <= field_nxt;
      field_onehot <= to_onehot(field_nxt);
      blink        <= blink_nxt;
      moved        <= sel_live && (field_nxt != field);
      timeout      <= idle_wrap;
    end
  end

endmodule
